// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: A - B - bin, one bit per clock, LSB first.
// One full-subtractor cell is time-shared across all WIDTH bit positions.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sd;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             d;
    logic             nb;
    logic [WIDTH-1:0] sd_next;

    always_comb begin
        d       = sa[0] ^ sb[0] ^ br;
        nb      = (~sa[0] & sb[0]) | (~sa[0] & br) | (sb[0] & br);
        sd_next = {d, sd[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            sa    <= '0;
            sb    <= '0;
            sd    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        br    <= bin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    sd  <= sd_next;
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    br  <= nb;
                    cnt <= cnt + CW'(1);
                    // Final bit: publish the result alongside the last shift
                    if (cnt == CW'(WIDTH - 1)) begin
                        diff  <= sd_next;
                        bout  <= nb;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: behavioural model plus
// directed cases with literal expectations and a randomized phase.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    int total;
    int bad;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: k = cycle index since acceptance (1..W busy, W+1 done, 0 idle)
    int         k;
    logic [W:0] m_res;
    logic [W-1:0] m_diff;
    logic       m_bout;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k      <= 0;
            m_diff <= '0;
            m_bout <= 1'b0;
            m_res  <= '0;
        end else if ((k == 0 || k == W + 1) && start) begin
            k     <= 1;
            m_res <= {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        end else if (k >= 1 && k < W) begin
            k <= k + 1;
        end else if (k == W) begin
            k      <= W + 1;
            m_diff <= m_res[W-1:0];
            m_bout <= m_res[W];
        end else begin
            k <= 0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("busy", int'(busy), int'(k >= 1 && k <= W));
        chk("done", int'(done), int'(k == W + 1));
        chk("diff", int'(diff), int'(m_diff));
        chk("bout", int'(bout), int'(m_bout));
    end

    // Launch an operation from idle and wait (bounded) for its done pulse
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tbin, output int busy_cyc, output int lat);
        @(posedge clk);
        #1;
        start = 1'b1;
        a     = ta;
        b     = tb_;
        bin   = tbin;
        @(posedge clk);
        #1;
        start    = 1'b0;
        busy_cyc = 0;
        lat      = 0;
        for (int i = 0; i < 3 * W; i++) begin
            @(negedge clk);
            lat++;
            if (busy) busy_cyc++;
            if (done) break;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL timeout: no done within %0d cycles", 3 * W);
        end
    endtask

    task automatic res(input string name, input int ed, input int eb);
        chk({name, "_diff"}, int'(diff), ed);
        chk({name, "_bout"}, int'(bout), eb);
        chk({name, "_model"}, int'(m_diff), ed);
    endtask

    int bc;
    int lt;
    int dones;

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_diff", int'(diff), 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(8'h5A, 8'h3C, 1'b0, bc, lt);
        chk("t1_busy_cycles", bc, 8);
        chk("t1_latency", lt, 9);
        res("t1", 'h1E, 0);

        do_op(8'h00, 8'h01, 1'b0, bc, lt);
        res("t2a", 'hFF, 1);
        do_op(8'h10, 8'h10, 1'b1, bc, lt);
        res("t2b", 'hFF, 1);
        do_op(8'hFF, 8'h00, 1'b0, bc, lt);
        res("t3a", 'hFF, 0);
        do_op(8'h80, 8'h7F, 1'b1, bc, lt);
        res("t3b", 'h00, 0);

        // Start while busy must be ignored
        @(posedge clk);
        #1;
        start = 1'b1; a = 8'h5A; b = 8'h3C; bin = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        start = 1'b1; a = 8'h01; b = 8'h02;
        @(posedge clk);
        #1;
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 2 * W + 4; i++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                res("t4", 'h1E, 0);
            end
        end
        chk("t4_done_count", dones, 1);

        // Back-to-back: new request presented during the DONE cycle
        do_op(8'h20, 8'h05, 1'b0, bc, lt);
        res("t5a", 'h1B, 0);
        start = 1'b1; a = 8'h09; b = 8'h03; bin = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("t5_no_idle", int'(busy), 1);
        lt = 1;
        for (int i = 0; i < 3 * W; i++) begin
            if (done) break;
            @(negedge clk);
            lt++;
        end
        chk("t5_latency", lt, 9);
        res("t5b", 'h06, 0);

        // Reset in the middle of SHIFT
        @(posedge clk);
        #1;
        start = 1'b1; a = 8'h5A; b = 8'h3C; bin = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_busy", int'(busy), 0);
        chk("t6_done", int'(done), 0);
        chk("t6_diff", int'(diff), 0);
        chk("t6_bout", int'(bout), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("t6_no_done", dones, 0);
        do_op(8'h03, 8'h05, 1'b0, bc, lt);
        res("t6", 'hFE, 1);

        // Randomized traffic; the per-cycle compare checks everything
        for (int i = 0; i < 800; i++) begin
            @(posedge clk);
            #1;
            start = ($urandom_range(0, 2) == 0);
            a     = W'($urandom);
            b     = W'($urandom);
            bin   = 1'($urandom);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (W + 3) @(posedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial full subtractor: computes A - B - bin over WIDTH cycles, one bit per clock, LSB first.
- Uses a single full-subtractor cell and a registered borrow.
- Counterpart to the team's combinational full-adder cell, for area-constrained datapaths where one ALU bit-slice is time-shared.
- Operands are loaded in parallel with a start/busy/done handshake; the result is presented in parallel.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2.

Ports:
- clk    input   1      rising-edge clock
- rst_n  input   1      asynchronous active-low reset
- start  input   1      request; sampled only when the block is idle (IDLE or DONE)
- a      input   WIDTH  minuend; captured on the accepting edge
- b      input   WIDTH  subtrahend; captured on the accepting edge
- bin    input   1      borrow-in; captured on the accepting edge
- busy   output  1      high while the block is computing (state SHIFT)
- done   output  1      one-cycle pulse; diff and bout are valid
- diff   output  WIDTH  difference (A - B - bin) mod 2^WIDTH
- bout   output  1      borrow-out; 1 when A < B + bin (unsigned)

Behaviour:
- Reset: rst_n low asynchronously forces:
  - state = IDLE, busy = 0, done = 0;
  - diff = 0, bout = 0;
  - internal shift registers, borrow flop and counter = 0.
- Reset mid-operation aborts the calculation with no done pulse; the block restarts in IDLE after rst_n deasserts.
- Registers:
  - sa, sb: WIDTH-bit operand shift registers.
  - br: borrow flop.
  - sd: WIDTH-bit result shift register.
  - cnt: bit counter, width $clog2(WIDTH+1).
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start = 1 at an edge loads sa <- a, sb <- b, br <- bin, cnt <- 0, then moves to SHIFT.
  - Otherwise the state holds.
- SHIFT, each edge:
  - Per-bit cell: d = sa[0] ^ sb[0] ^ br; nb = (~sa[0] & sb[0]) | (~sa[0] & br) | (sb[0] & br).
  - sd <- {d, sd[WIDTH-1:1]}; sa and sb shift right by 1 (zero fill); br <- nb; cnt <- cnt + 1.
  - On the edge where cnt == WIDTH-1, i.e. after the final bit: diff <- {d, sd[WIDTH-1:1]}, bout <- nb, done <- 1, state -> DONE.
- DONE:
  - Lasts exactly one cycle with done = 1; done returns to 0 on the next edge.
  - start = 1 here is accepted exactly as in IDLE (back-to-back operation) and moves to SHIFT.
  - Otherwise the state moves to IDLE.
- Latency: start is accepted at edge E0. Bits are processed on edges E1..EWIDTH. done is high in the cycle following EWIDTH. Total WIDTH+1 edges from acceptance to done.
- busy is high from the cycle after E0 through the cycle ending at EWIDTH (WIDTH cycles). busy is registered and decoded from the state.
- start while busy is ignored: a, b and bin are not captured, and the operation in progress is unaffected.
- diff and bout hold their last values until the next completion. They are not cleared by start.
- No overflow detection: the result is unsigned modulo 2^WIDTH, and bout is the only wrap indicator.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Test Plan (WIDTH = 8):
- a=0x5A, b=0x3C, bin=0, pulse start:
  - busy is high for exactly 8 cycles.
  - done pulses in the 9th cycle after acceptance, with diff=0x1E, bout=0.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1. Then a=0x10, b=0x10, bin=1 -> diff=0xFF, bout=1.
- a=0xFF, b=0x00, bin=0 -> diff=0xFF, bout=0. Then a=0x80, b=0x7F, bin=1 -> diff=0x00, bout=0.
- Start during busy: start 0x5A-0x3C, then on cycle 3 pulse start with a=0x01, b=0x02.
  - The second request is ignored.
  - diff=0x1E, bout=0, and only one done pulse occurs.
- Back-to-back: hold start=1 through the DONE cycle with a=0x09, b=0x03, bin=0.
  - The first result completes normally.
  - A new operation starts with no IDLE cycle; the second done gives diff=0x06, bout=0.
- Reset mid-operation: assert rst_n=0 on cycle 4 of SHIFT.
  - busy, done, diff and bout go to 0 immediately (asynchronous), and no done pulse follows.
  - After release, a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1.
